// File: rtl/inst_fetch_cache_pkg.sv
// Shared types and helpers for the instruction-fetch cache.
// Holds the fetch FSM encoding and the saturating counter helper.
package inst_fetch_cache_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_TOUT = 2'b10
    } fetch_state_t;

    localparam logic        RST_ENABLE  = 1'b1;
    localparam logic        CHIP_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: tag, valid and one data word per line.
// Combinational read, one synchronous write port, synchronous clear-all.
module icache_array
    import inst_fetch_cache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES];

    // Valid bits: clear-all dominates any fill written the same edge.
    always_ff @(posedge clk) begin
        if (clr == RST_ENABLE) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_valid;
        end
    end

    // Tag and data payload; a fill always overwrites the aliased line.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/inst_fetch_cache.sv
// Instruction-fetch front end: small direct-mapped cache in front of a
// slow req/ack instruction memory, with bus timeout, flush and miss count.
module inst_fetch_cache
    import inst_fetch_cache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LINES   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              stallreq_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              err_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    fetch_state_t state;
    logic [31:0]  tcnt;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              miss;
    logic              fill;
    logic              timeout_hit;
    logic              unused_addr_bits;

    assign idx      = addr_i[2+IDX_W-1:2];
    assign tag      = addr_i[ADDR_W-1:2+IDX_W];
    assign fill_idx = mem_addr_o[2+IDX_W-1:2];
    assign fill_tag = mem_addr_o[ADDR_W-1:2+IDX_W];

    // Byte offset within the word is irrelevant to instruction fetch.
    assign unused_addr_bits = ^addr_i[1:0];

    // A flush in the same cycle forces a miss so stale lines are never used.
    assign hit = (state == FETCH_IDLE) && (ce_i == CHIP_ENABLE) && !flush_i
               && rd_valid && (rd_tag == tag);
    assign miss = (state == FETCH_IDLE) && (ce_i == CHIP_ENABLE) && !hit;
    assign fill = (state == FETCH_REQ) && mem_ack_i;

    // Count check uses the post-increment value so the request lasts
    // exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 0) && (tcnt + 32'd1 == 32'(TIMEOUT));

    icache_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .clr      (rst | flush_i),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill & ~rst),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_data  (mem_data_i),
        .wr_valid (~flush_i)
    );

    // Core-facing outputs: hit data is returned in the same cycle.
    always_comb begin
        inst_o     = '0;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            if (hit) begin
                inst_o = rd_data;
            end
            stallreq_o = miss || (state == FETCH_REQ);
        end
    end

    // Fetch FSM with registered memory request, error flag and counters.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= FETCH_IDLE;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            err_o      <= 1'b0;
            miss_cnt_o <= '0;
            tcnt       <= '0;
        end else begin
            unique case (state)
                FETCH_IDLE: begin
                    if (miss) begin
                        mem_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
                        mem_req_o  <= 1'b1;
                        miss_cnt_o <= sat_inc(miss_cnt_o);
                        tcnt       <= '0;
                        state      <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        tcnt      <= '0;
                        state     <= FETCH_IDLE;
                    end else if (timeout_hit) begin
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        tcnt      <= '0;
                        state     <= FETCH_TOUT;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                FETCH_TOUT: begin
                    state <= FETCH_IDLE;
                end
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Directed self-checking bench for inst_fetch_cache.
// Drives fetches against a scripted slow memory and checks stall timing.
module tb_inst_fetch_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        err_o;
    logic [31:0] miss_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_fetch_cache #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .LINES   (16),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .inst_o     (inst_o),
        .stallreq_o (stallreq_o),
        .flush_i    (flush_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .err_o      (err_o),
        .miss_cnt_o (miss_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One core fetch: hold pc until stall drops; memory acks on the
    // (k+1)th cycle of each request (k<0 never acks).
    task automatic fetch(input logic [31:0] pc, input int k,
                         input logic [31:0] data, input bit fl,
                         output int stalls, output logic [31:0] inst,
                         output logic [31:0] raddr, output int reqs,
                         output int req_cycles);
        int rc;
        bit done;
        bit fl_left;
        rc = 0;
        stalls = 0;
        inst = '0;
        raddr = '0;
        reqs = 0;
        req_cycles = 0;
        done = 1'b0;
        fl_left = fl;
        @(posedge clk);
        #1;
        addr_i = pc;
        ce_i = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stallreq_o) begin
                inst = inst_o;
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req_o) begin
                    if (rc == 0) reqs++;
                    req_cycles++;
                    raddr = mem_addr_o;
                    if (rc == k) begin
                        mem_ack_i = 1'b1;
                        mem_data_i = data;
                        if (fl_left) begin
                            flush_i = 1'b1;
                            fl_left = 1'b0;
                        end
                    end
                    rc++;
                end else begin
                    rc = 0;
                end
                @(posedge clk);
                #1;
                mem_ack_i = 1'b0;
                flush_i = 1'b0;
            end
        end
        check("fetch_done", 32'(done), 32'd1);
    endtask

    int          st;
    int          rq;
    int          rcy;
    logic [31:0] ins;
    logic [31:0] ra;

    initial begin
        rst = 1'b1;
        ce_i = 1'b1;
        addr_i = '0;
        flush_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_inst", inst_o, 32'h0);
        @(posedge clk);
        #1;
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_miss", miss_cnt_o, 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        rst = 1'b0;
        ce_i = 1'b0;

        // Cold fetch with two-cycle memory latency
        fetch(32'h0, 2, 32'h3401_1100, 1'b0, st, ins, ra, rq, rcy);
        check("cold_stalls", 32'(st), 32'd4);
        check("cold_addr", ra, 32'h0);
        check("cold_inst", ins, 32'h3401_1100);
        check("cold_miss", miss_cnt_o, 32'd1);

        // Re-fetch hits with no memory traffic
        fetch(32'h0, -1, 32'h0, 1'b0, st, ins, ra, rq, rcy);
        check("hit_stalls", 32'(st), 32'd0);
        check("hit_req", 32'(rcy), 32'd0);
        check("hit_inst", ins, 32'h3401_1100);
        check("hit_miss", miss_cnt_o, 32'd1);

        // Byte offset bits do not affect lookup
        fetch(32'h3, -1, 32'h0, 1'b0, st, ins, ra, rq, rcy);
        check("off_stalls", 32'(st), 32'd0);
        check("off_inst", ins, 32'h3401_1100);

        // Aliasing: 0x40 evicts 0x0 from line 0
        fetch(32'h40, 1, 32'hAAAA_0040, 1'b0, st, ins, ra, rq, rcy);
        check("alias_stalls", 32'(st), 32'd3);
        check("alias_addr", ra, 32'h40);
        check("alias_inst", ins, 32'hAAAA_0040);
        fetch(32'h0, 0, 32'h3401_1100, 1'b0, st, ins, ra, rq, rcy);
        check("realias_stalls", 32'(st), 32'd2);
        check("realias_inst", ins, 32'h3401_1100);
        check("realias_miss", miss_cnt_o, 32'd3);

        // Fetch disabled
        @(posedge clk);
        #1;
        ce_i = 1'b0;
        addr_i = 32'h0;
        @(negedge clk);
        check("ce0_inst", inst_o, 32'h0);
        check("ce0_stall", 32'(stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        check("ce0_req", 32'(mem_req_o), 32'd0);

        // Flush together with ack: line stays invalid, 0x8 re-requested
        fetch(32'h8, 1, 32'h8888_0008, 1'b1, st, ins, ra, rq, rcy);
        check("flush_stalls", 32'(st), 32'd6);
        check("flush_reqs", 32'(rq), 32'd2);
        check("flush_addr", ra, 32'h8);
        check("flush_inst", ins, 32'h8888_0008);
        check("flush_miss", miss_cnt_o, 32'd5);

        // Flush in IDLE forces a miss on a valid line
        @(posedge clk);
        #1;
        addr_i = 32'h8;
        ce_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        check("fidle_stall", 32'(stallreq_o), 32'd1);
        check("fidle_inst", inst_o, 32'h0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("fidle_req", 32'(mem_req_o), 32'd1);
        fetch(32'h8, 0, 32'h8888_0008, 1'b0, st, ins, ra, rq, rcy);
        check("fidle_inst2", ins, 32'h8888_0008);
        check("fidle_miss", miss_cnt_o, 32'd6);

        // Timeout: memory never acks
        fetch(32'h20, -1, 32'h0, 1'b0, st, ins, ra, rq, rcy);
        check("tout_stalls", 32'(st), 32'd9);
        check("tout_reqcyc", 32'(rcy), 32'd8);
        check("tout_inst", ins, 32'h0);
        check("tout_req", 32'(mem_req_o), 32'd0);
        check("tout_err", 32'(err_o), 32'd1);
        ce_i = 1'b0;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b1;
        mem_data_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        check("late_req", 32'(mem_req_o), 32'd0);
        check("late_err", 32'(err_o), 32'd1);
        check("late_miss", miss_cnt_o, 32'd7);
        fetch(32'h20, 1, 32'h2020_2020, 1'b0, st, ins, ra, rq, rcy);
        check("late_stalls", 32'(st), 32'd3);
        check("late_inst", ins, 32'h2020_2020);
        check("late_err2", 32'(err_o), 32'd1);

        // Reset during an outstanding request
        @(posedge clk);
        #1;
        addr_i = 32'h10;
        ce_i = 1'b1;
        @(posedge clk);
        #1;
        check("mid_req", 32'(mem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_stall", 32'(stallreq_o), 32'd0);
        check("mid_inst", inst_o, 32'h0);
        @(posedge clk);
        #1;
        check("mid_req0", 32'(mem_req_o), 32'd0);
        check("mid_err0", 32'(err_o), 32'd0);
        check("mid_miss0", miss_cnt_o, 32'd0);
        rst = 1'b0;
        ce_i = 1'b0;
        fetch(32'h0, 0, 32'h3401_1100, 1'b0, st, ins, ra, rq, rcy);
        check("post_stalls", 32'(st), 32'd2);
        check("post_inst", ins, 32'h3401_1100);
        check("post_miss", miss_cnt_o, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_cache.md
Name: inst_fetch_cache

Overview:
- Parametrised instruction-fetch front end between the openmips core fetch port and a slow instruction memory with a req/ack handshake.
- Replaces the zero-latency direct ROM hookup in the SOPC top.
- Holds a small direct-mapped, one-word-per-line cache. Hits return combinationally; misses stall the pipeline through stallreq_o.
- Adds a bus timeout, flush, and a miss counter.

Parameters:
- ADDR_W, 32, fetch/memory address width.
- DATA_W, 32, instruction width.
- LINES, 16, cache lines; power of 2, ≥2. IDX_W = log2(LINES).
- TIMEOUT, 255, max cycles waiting for mem_ack_i; 0 disables the timeout.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ce_i  in  1  core fetch enable.
- addr_i  in  ADDR_W  core fetch PC.
- inst_o  out  DATA_W  instruction to the core.
- stallreq_o  out  1  pipeline stall request.
- flush_i  in  1  invalidate all lines.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  ADDR_W  memory word address.
- mem_ack_i  in  1  memory data valid.
- mem_data_i  in  DATA_W  memory read data.
- err_o  out  1  sticky timeout flag.
- miss_cnt_o  out  32  saturating miss count.

Behaviour:
- Address split:
  - idx = addr_i[2+IDX_W-1:2].
  - tag = addr_i[ADDR_W-1:2+IDX_W].
  - addr_i[1:0] ignored.
- Reset, applied at the clock edge with rst=1:
  - all valid bits cleared; state=IDLE.
  - mem_req_o=0, mem_addr_o=0, err_o=0, miss_cnt_o=0, timeout counter=0.
  - stallreq_o=0 and inst_o=0 while rst=1.
  - Reset mid-REQ drops mem_req_o at that same edge.
- ce_i=0: inst_o=0, stallreq_o=0, no new request. An in-flight REQ still completes and fills.
- IDLE, hit (valid[idx] && tag match && ce_i): inst_o=data[idx] and stallreq_o=0 in the same cycle (0-cycle latency).
- IDLE, miss with ce_i=1:
  - stallreq_o=1 and inst_o=0 combinationally.
  - Next edge: mem_addr_o <= {addr_i[ADDR_W-1:2],2'b00}; mem_req_o <= 1; miss_cnt_o increments, saturating at 0xFFFFFFFF; state <= REQ.
- REQ:
  - stallreq_o=1, inst_o=0.
  - mem_req_o and mem_addr_o held stable until ack.
  - On mem_ack_i=1 (ack may come in the first REQ cycle): write data/tag/valid for mem_addr_o's idx; mem_req_o <= 0; state <= IDLE.
  - The core holds addr_i during the stall, so the next cycle hits.
  - Miss timing: ack k cycles after the first REQ cycle gives 2+k stall cycles.
- Timeout (TIMEOUT>0):
  - The counter increments each REQ cycle without ack.
  - When the counter equals TIMEOUT: mem_req_o <= 0; err_o <= 1 (sticky until rst); state <= TOUT; no fill.
- TOUT, one cycle: inst_o=0 (NOP), stallreq_o=0; state <= IDLE. The core consumes a NOP. mem_ack_i arriving in IDLE/TOUT is ignored.
- flush_i:
  - Clears all valid bits at the edge.
  - In IDLE with flush_i=1, the hit check is forced to miss that cycle.
  - In REQ, the fill at ack is written with valid=0; the data is still delivered via re-miss.
  - flush_i and mem_ack_i in the same cycle: flush wins, line invalid, state <= IDLE.
- Index aliasing: a fill overwrites the line regardless of its previous contents.

Decomposition:
- defines.v additions: RstEnable, ChipEnable, ZeroWord, InstAddrBus, InstBus (existing), plus FetchIdle/FetchReq/FetchTout 2-bit state encodings.
- One sub-module, icache_array: LINES×(tag+valid+data) storage with combinational read, one synchronous write port, and a synchronous clear-all for flush/rst.
- The FSM, timeout counter and miss counter stay in inst_fetch_cache.

Test Plan:
1. Cold fetch, LINES=16, TIMEOUT=255, memory ack latency k=2:
   - Stimulus: PC=0x00000000, ce_i=1, memory returns 0x34011100.
   - Required: stallreq_o high 4 cycles; mem_addr_o=0x0; then inst_o=0x34011100, stallreq_o=0; miss_cnt_o=1.
2. Re-fetch:
   - Stimulus: fetch PC 0x0 again.
   - Required: 0-cycle hit; no mem_req_o; miss_cnt_o stays 1.
3. Aliasing:
   - Stimulus: fetch 0x40 after 0x0 (same idx, different tag).
   - Required: miss, fill. Re-fetching 0x0 misses again; miss_cnt_o=3.
4. Timeout, TIMEOUT=8:
   - Stimulus: memory never acks.
   - Required: mem_req_o drops after 8 REQ cycles; inst_o=0 with stallreq_o=0 for one cycle; err_o=1 and held; a late ack is ignored.
5. Flush:
   - Stimulus: flush_i asserted on the same cycle as mem_ack_i for PC 0x8.
   - Required: line not valid; the following cycle misses again and re-requests 0x8.
6. Reset mid-REQ:
   - Stimulus: rst=1 during REQ.
   - Required: mem_req_o=0, err_o=0, miss_cnt_o=0 after the edge; the first fetch after rst misses.
